clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//  User-interface sequencer for the multi-mode clock. Turns five debounced buttons into mode
//  changes and single-cycle inc/dec strobes for the time counter and alarm_clock set fields.
//  Also drives alarm enable/dismiss and display blink. Sits between the button debouncers and
//  the time counter / alarm_clock instances.
// PARAMETERS
//  IDLE_TIMEOUT  10  tick_1hz pulses with no button edge in a SET state before forced return to RUN
//  REPEAT_DELAY  8   tick_fast pulses up/down must be held before the first auto-repeat strobe
//  REPEAT_RATE   2   tick_fast pulses between further auto-repeat strobes (>=1)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  tick_1hz   in   1  one-cycle pulse, 1 Hz
//  tick_fast  in   1  one-cycle pulse, 8 Hz (blink and repeat timebase)
//  btn_mode   in   1  debounced level, mode button
//  btn_sel    in   1  debounced level, field-select button
//  btn_up     in   1  debounced level, increment
//  btn_down   in   1  debounced level, decrement
//  btn_stop   in   1  debounced level, alarm dismiss
//  alarming   in   1  alarm_clock alarming flag
//  mode       out  2  0=RUN 1=SET_TIME 2=SET_ALARM (3 unused)
//  field      out  3  one-hot selected field: [0]=sec [1]=min [2]=hour
//  time_inc   out  3  one-cycle strobe to time counter, bit per field
//  time_dec   out  3  as time_inc, decrement
//  alarm_inc  out  3  to alarm_clock signal_increase
//  alarm_dec  out  3  to alarm_clock signal_decrease
//  alarm_en   out  1  to alarm_clock en
//  dis_alarm  out  1  one-cycle strobe to alarm_clock dis_alarm
//  time_hold  out  1  high in SET_TIME; time counter stops advancing
//  blink      out  1  display blink phase for selected field
// BEHAVIOUR
//  Reset: mode=RUN, field=3'b100, alarm_en=0, blink=0, all strobes 0, time_hold=0, counters 0.
//  Button edge = prev sample 0, current 1 (prev regs reset to 0). Every strobe is registered:
//  edge sampled at cycle n -> strobe high only in cycle n+1.
//  FSM: RUN -mode-> SET_TIME -mode-> SET_ALARM -mode-> RUN. Entering any SET state sets field=100.
//  Same-cycle edge priority: mode > sel > up/down; lower-priority edges in that cycle are dropped.
//  sel (SET states only): field rotates 100->001->010->100. Ignored in RUN.
//  up/down in SET_TIME -> time_inc/time_dec = field; in SET_ALARM -> alarm_inc/alarm_dec = field.
//  up and down edges in same cycle -> no strobe. Never inc and dec together.
//  RUN: up edge toggles alarm_en; down ignored.
//  stop edge in any state -> dis_alarm pulse only if alarming=1; no other effect.
//  Idle counter: cleared on any button edge or on mode change; +1 on tick_1hz in SET states.
//  Reaching IDLE_TIMEOUT -> mode=RUN next cycle, counter cleared. In RUN it is held at 0.
//  blink: toggles on tick_fast in SET states; forced 0 in RUN and on entering a SET state.
//  time_hold = (mode==SET_TIME), registered with mode.
//  Reset asserted mid-operation overrides all, including pending strobes.
// CONFIGURATION
//  CLOCK_CTRL_AUTOREPEAT_EN defined: in SET states, up or down held alone counts tick_fast.
//   First repeat strobe after REPEAT_DELAY ticks, then one every REPEAT_RATE ticks.
//   Hold counter clears on release, on both held, or on mode/sel edge.
//   Repeat strobe does not clear the idle counter.
//  Not defined: exactly one strobe per press; no hold counter logic present.
// STRUCTURE
//  clock_ctrl_pkg: MODE_RUN/MODE_SET_TIME/MODE_SET_ALARM, FIELD_SEC/MIN/HOUR one-hot constants.
//  Sub-module btn_repeat (x2, up and down): edge detect plus optional hold/repeat counter.
//   Outputs one-cycle press_evt. FSM, field rotation and strobe routing stay in the top.
// TESTING
//  1 rst; mode,sel,up edges in one cycle -> mode=SET_TIME, field=100, no inc strobe.
//  2 SET_ALARM, sel x1, up edge at n -> alarm_inc=001 for cycle n+1 only; time_inc stays 000.
//  3 SET_TIME, 10 tick_1hz, no buttons -> mode=RUN after 10th tick, time_hold falls.
//    Repeat with a press after tick 9 -> no timeout until 10 more ticks.
//  4 RUN, up edge -> alarm_en 0->1; stop edge with alarming=0 -> no dis_alarm;
//    stop edge with alarming=1 -> dis_alarm 1 cycle.
//  5 SET_TIME, up+down same cycle -> no strobe.
//    AUTOREPEAT_EN: hold up 14 tick_fast -> strobes after ticks 0(edge), 8, 10, 12, 14.
//  6 rst asserted cycle after up edge -> strobe suppressed, all outputs at reset values.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared mode/field encodings for the clock user-interface sequencer.
// Mode order and field rotation helpers live here so the top stays readable.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  localparam logic [2:0] FIELD_SEC  = 3'b001;
  localparam logic [2:0] FIELD_MIN  = 3'b010;
  localparam logic [2:0] FIELD_HOUR = 3'b100;

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    unique case (m)
      MODE_RUN:      r = MODE_SET_TIME;
      MODE_SET_TIME: r = MODE_SET_ALARM;
      default:       r = MODE_RUN;
    endcase
    return r;
  endfunction

  // hour -> sec -> min -> hour
  function automatic logic [2:0] next_field(input logic [2:0] f);
    return {f[1:0], f[2]};
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector for up/down with optional hold-to-repeat.
// Repeat support is built only when CLOCK_CTRL_AUTOREPEAT_EN is defined.
module btn_repeat #(
  parameter int unsigned DELAY = 8,
  parameter int unsigned RATE  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic other_i,
  input  logic tick_i,
  input  logic arm_i,
  input  logic clr_i,
  output logic edge_o,
  output logic press_evt_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

  assign edge_o = btn_i & ~prev_q;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  localparam int unsigned CW = $clog2(DELAY + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt;
  logic          alone;

  assign alone = btn_i & ~other_i;

  // After the first repeat, restart RATE ticks short of the trigger point
  always_comb begin
    cnt_d = cnt_q;
    rpt   = 1'b0;
    if (!alone || !arm_i || clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(DELAY - 1)) begin
        rpt   = 1'b1;
        cnt_d = CW'(DELAY - RATE);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign press_evt_o = edge_o | rpt;
`else
  localparam int unsigned unused_cfg_p = DELAY + RATE;
  logic unused_in;
  assign unused_in   = ^{other_i, tick_i, arm_i, clr_i};
  assign press_evt_o = edge_o;
`endif

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button sequencer for the multi-mode clock: mode FSM, field select, strobes.
// Optional hold-to-repeat on up/down: CLOCK_CTRL_AUTOREPEAT_EN.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 10,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic       alarming,
  output logic [1:0] mode,
  output logic [2:0] field,
  output logic [2:0] time_inc,
  output logic [2:0] time_dec,
  output logic [2:0] alarm_inc,
  output logic [2:0] alarm_dec,
  output logic       alarm_en,
  output logic       dis_alarm,
  output logic       time_hold,
  output logic       blink
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  mode_e         mode_q, mode_d;
  logic [2:0]    field_q, field_d;
  logic          alarm_en_q, alarm_en_d;
  logic          blink_q, blink_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [2:0]    tinc_q, tinc_d, tdec_q, tdec_d;
  logic [2:0]    ainc_q, ainc_d, adec_q, adec_d;
  logic          dis_q, dis_d;
  logic          pmode_q, psel_q, pstop_q;

  logic mode_edge, sel_edge, stop_edge;
  logic up_edge, dn_edge, up_evt, dn_evt;
  logic in_set, any_edge;

  assign mode_edge = btn_mode & ~pmode_q;
  assign sel_edge  = btn_sel  & ~psel_q;
  assign stop_edge = btn_stop & ~pstop_q;
  assign in_set    = (mode_q != MODE_RUN);
  assign any_edge  = mode_edge | sel_edge | stop_edge | up_edge | dn_edge;

  btn_repeat #(
    .DELAY(REPEAT_DELAY),
    .RATE (REPEAT_RATE)
  ) u_up (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (btn_up),
    .other_i    (btn_down),
    .tick_i     (tick_fast),
    .arm_i      (in_set),
    .clr_i      (mode_edge | sel_edge),
    .edge_o     (up_edge),
    .press_evt_o(up_evt)
  );

  btn_repeat #(
    .DELAY(REPEAT_DELAY),
    .RATE (REPEAT_RATE)
  ) u_dn (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (btn_down),
    .other_i    (btn_up),
    .tick_i     (tick_fast),
    .arm_i      (in_set),
    .clr_i      (mode_edge | sel_edge),
    .edge_o     (dn_edge),
    .press_evt_o(dn_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      field_q    <= FIELD_HOUR;
      alarm_en_q <= 1'b0;
      blink_q    <= 1'b0;
      idle_q     <= '0;
      tinc_q     <= '0;
      tdec_q     <= '0;
      ainc_q     <= '0;
      adec_q     <= '0;
      dis_q      <= 1'b0;
      pmode_q    <= 1'b0;
      psel_q     <= 1'b0;
      pstop_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      alarm_en_q <= alarm_en_d;
      blink_q    <= blink_d;
      idle_q     <= idle_d;
      tinc_q     <= tinc_d;
      tdec_q     <= tdec_d;
      ainc_q     <= ainc_d;
      adec_q     <= adec_d;
      dis_q      <= dis_d;
      pmode_q    <= btn_mode;
      psel_q     <= btn_sel;
      pstop_q    <= btn_stop;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    field_d    = field_q;
    alarm_en_d = alarm_en_q;
    blink_d    = blink_q;
    idle_d     = idle_q;
    tinc_d     = '0;
    tdec_d     = '0;
    ainc_d     = '0;
    adec_d     = '0;
    dis_d      = stop_edge & alarming;

    if (!in_set)              idle_d = '0;
    else if (any_edge)        idle_d = '0;
    else if (tick_1hz)        idle_d = idle_q + 1'b1;

    if (!in_set)              blink_d = 1'b0;
    else if (tick_fast)       blink_d = ~blink_q;

    if (mode_edge) begin
      mode_d  = next_mode(mode_q);
      idle_d  = '0;
      blink_d = 1'b0;
      if (mode_d != MODE_RUN) field_d = FIELD_HOUR;
    end else if (in_set && idle_d == IW'(IDLE_TIMEOUT)) begin
      mode_d  = MODE_RUN;
      idle_d  = '0;
      blink_d = 1'b0;
    end else if (in_set && sel_edge) begin
      field_d = next_field(field_q);
    end else begin
      unique case (1'b1)
        mode_q == MODE_SET_TIME: begin
          if (up_evt && !dn_evt) tinc_d = field_q;
          if (dn_evt && !up_evt) tdec_d = field_q;
        end
        mode_q == MODE_SET_ALARM: begin
          if (up_evt && !dn_evt) ainc_d = field_q;
          if (dn_evt && !up_evt) adec_d = field_q;
        end
        default: begin
          if (up_edge) alarm_en_d = ~alarm_en_q;
        end
      endcase
    end
  end

  always_comb begin
    mode      = mode_q;
    field     = field_q;
    time_inc  = tinc_q;
    time_dec  = tdec_q;
    alarm_inc = ainc_q;
    alarm_dec = adec_q;
    alarm_en  = alarm_en_q;
    dis_alarm = dis_q;
    time_hold = (mode_q == MODE_SET_TIME);
    blink     = blink_q;
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: stimulus queues expectations,
// a monitor checks them just after the clock edge they refer to.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_fast = 1'b0;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0;
  logic       btn_down = 1'b0, btn_stop = 1'b0;
  logic       alarming = 1'b0;
  logic [1:0] mode;
  logic [2:0] field, time_inc, time_dec, alarm_inc, alarm_dec;
  logic       alarm_en, dis_alarm, time_hold, blink;

  clock_mode_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up),
    .btn_down(btn_down), .btn_stop(btn_stop), .alarming(alarming),
    .mode(mode), .field(field), .time_inc(time_inc), .time_dec(time_dec),
    .alarm_inc(alarm_inc), .alarm_dec(alarm_dec), .alarm_en(alarm_en),
    .dis_alarm(dis_alarm), .time_hold(time_hold), .blink(blink)
  );

  always #5 clk = ~clk;

  localparam int S_MODE = 0, S_FIELD = 1, S_TINC = 2, S_TDEC = 3;
  localparam int S_AINC = 4, S_ADEC = 5, S_AEN = 6, S_DIS = 7;
  localparam int S_HOLD = 8, S_BLINK = 9;

  localparam logic [4:0] B_MODE = 5'b10000, B_SEL = 5'b01000;
  localparam logic [4:0] B_UP = 5'b00100, B_DN = 5'b00010;
  localparam logic [4:0] B_STOP = 5'b00001, B_NONE = 5'b00000;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [7:0] get(input int s);
    logic [7:0] v;
    case (s)
      S_MODE:  v = {6'd0, mode};
      S_FIELD: v = {5'd0, field};
      S_TINC:  v = {5'd0, time_inc};
      S_TDEC:  v = {5'd0, time_dec};
      S_AINC:  v = {5'd0, alarm_inc};
      S_ADEC:  v = {5'd0, alarm_dec};
      S_AEN:   v = {7'd0, alarm_en};
      S_DIS:   v = {7'd0, dis_alarm};
      S_HOLD:  v = {7'd0, time_hold};
      default: v = {7'd0, blink};
    endcase
    return v;
  endfunction

  // Monitor: outputs are registered, so check #1 after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        chk_t c;
        c = sb.pop_front();
        n_chk++;
        if (get(c.sel) !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", c.name, get(c.sel), c.exp);
        end
      end
    end
  end

  task automatic ex(input string nm, input int s, input logic [7:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = s;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic cyc(input logic [4:0] b, input logic t1 = 1'b0,
                     input logic tf = 1'b0);
    @(negedge clk);
    {btn_mode, btn_sel, btn_up, btn_down, btn_stop} = b;
    tick_1hz  = t1;
    tick_fast = tf;
  endtask

  task automatic ticks_1hz(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(B_NONE, 1'b1);
      cyc(B_NONE);
    end
  endtask

  initial begin
    // reset
    cyc(B_NONE);
    ex("rst_mode", S_MODE, 8'd0);
    ex("rst_field", S_FIELD, 8'b100);
    ex("rst_aen", S_AEN, 8'd0);
    ex("rst_blink", S_BLINK, 8'd0);
    ex("rst_hold", S_HOLD, 8'd0);
    ex("rst_tinc", S_TINC, 8'd0);
    ex("rst_dis", S_DIS, 8'd0);
    cyc(B_NONE);
    rst = 1'b0;

    // 1: mode+sel+up together -> only the mode change
    cyc(B_MODE | B_SEL | B_UP);
    ex("t1_mode", S_MODE, 8'd1);
    ex("t1_field", S_FIELD, 8'b100);
    ex("t1_tinc", S_TINC, 8'd0);
    ex("t1_hold", S_HOLD, 8'd1);
    cyc(B_NONE);
    ex("t1_tinc_after", S_TINC, 8'd0);
    ex("t1_field_after", S_FIELD, 8'b100);

    // 2: SET_ALARM, sel once, up -> alarm_inc=001 for one cycle
    cyc(B_MODE);
    ex("t2_mode", S_MODE, 8'd2);
    ex("t2_hold", S_HOLD, 8'd0);
    cyc(B_NONE);
    cyc(B_SEL);
    ex("t2_field_sec", S_FIELD, 8'b001);
    cyc(B_NONE);
    cyc(B_UP);
    ex("t2_ainc", S_AINC, 8'b001);
    ex("t2_tinc", S_TINC, 8'd0);
    cyc(B_NONE);
    ex("t2_ainc_drop", S_AINC, 8'd0);
    cyc(B_DN);
    ex("t2_adec", S_ADEC, 8'b001);
    ex("t2_ainc_z", S_AINC, 8'd0);
    cyc(B_NONE);
    cyc(B_SEL);
    ex("t2_field_min", S_FIELD, 8'b010);
    cyc(B_NONE);
    cyc(B_SEL);
    ex("t2_field_hour", S_FIELD, 8'b100);
    cyc(B_NONE);
    cyc(B_MODE);
    ex("t2_back_run", S_MODE, 8'd0);
    cyc(B_NONE);

    // 4: RUN alarm enable and dismiss
    cyc(B_UP);
    ex("t4_aen_on", S_AEN, 8'd1);
    ex("t4_tinc", S_TINC, 8'd0);
    cyc(B_NONE);
    cyc(B_DN);
    ex("t4_aen_keep", S_AEN, 8'd1);
    ex("t4_tdec", S_TDEC, 8'd0);
    cyc(B_NONE);
    cyc(B_STOP);
    ex("t4_dis_quiet", S_DIS, 8'd0);
    cyc(B_NONE);
    alarming = 1'b1;
    cyc(B_STOP);
    ex("t4_dis_pulse", S_DIS, 8'd1);
    cyc(B_STOP);
    ex("t4_dis_once", S_DIS, 8'd0);
    cyc(B_NONE);
    alarming = 1'b0;

    // 3: idle timeout in SET_TIME, blink behaviour
    cyc(B_MODE);
    ex("t3_mode", S_MODE, 8'd1);
    ex("t3_blink0", S_BLINK, 8'd0);
    cyc(B_NONE, 1'b0, 1'b1);
    ex("t3_blink1", S_BLINK, 8'd1);
    cyc(B_NONE, 1'b0, 1'b1);
    ex("t3_blink2", S_BLINK, 8'd0);
    cyc(B_NONE, 1'b0, 1'b1);
    ex("t3_blink3", S_BLINK, 8'd1);
    ticks_1hz(9);
    ex("t3_still_set", S_MODE, 8'd1);
    cyc(B_NONE, 1'b1);
    ex("t3_timeout", S_MODE, 8'd0);
    ex("t3_hold_fall", S_HOLD, 8'd0);
    ex("t3_blink_off", S_BLINK, 8'd0);
    cyc(B_NONE);

    cyc(B_MODE);
    ex("t3b_mode", S_MODE, 8'd1);
    cyc(B_NONE);
    ticks_1hz(9);
    cyc(B_SEL);
    ex("t3b_sel", S_FIELD, 8'b001);
    cyc(B_NONE);
    ticks_1hz(9);
    ex("t3b_no_timeout", S_MODE, 8'd1);
    cyc(B_NONE, 1'b1);
    ex("t3b_timeout", S_MODE, 8'd0);
    cyc(B_NONE);

    // 5: up+down together -> nothing; single presses strobe field
    cyc(B_MODE);
    ex("t5_mode", S_MODE, 8'd1);
    ex("t5_field", S_FIELD, 8'b100);
    cyc(B_NONE);
    cyc(B_UP | B_DN);
    ex("t5_both_inc", S_TINC, 8'd0);
    ex("t5_both_dec", S_TDEC, 8'd0);
    cyc(B_NONE);
    ex("t5_both_inc2", S_TINC, 8'd0);
    cyc(B_UP);
    ex("t5_inc", S_TINC, 8'b100);
    ex("t5_ainc", S_AINC, 8'd0);
    cyc(B_NONE);
    ex("t5_inc_drop", S_TINC, 8'd0);
    cyc(B_DN);
    ex("t5_dec", S_TDEC, 8'b100);
    ex("t5_dec_noinc", S_TINC, 8'd0);
    cyc(B_NONE);

    // hold up through 14 fast ticks
    cyc(B_UP);
    ex("t5_hold_edge", S_TINC, 8'b100);
    for (int k = 1; k <= 14; k++) begin
      logic [7:0] e;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
      e = (k == 8 || k == 10 || k == 12 || k == 14) ? 8'b100 : 8'd0;
`else
      e = 8'd0;
`endif
      cyc(B_UP, 1'b0, 1'b1);
      ex($sformatf("t5_hold_tick%0d", k), S_TINC, e);
      cyc(B_UP);
      ex($sformatf("t5_hold_gap%0d", k), S_TINC, 8'd0);
    end
    cyc(B_NONE);
    cyc(B_NONE, 1'b0, 1'b1);
    ex("t6_pre_blink", S_BLINK, 8'd1);

    // 6: reset together with an up edge wipes everything
    @(negedge clk);
    rst = 1'b1;
    btn_up = 1'b1;
    ex("t6_tinc", S_TINC, 8'd0);
    ex("t6_mode", S_MODE, 8'd0);
    ex("t6_field", S_FIELD, 8'b100);
    ex("t6_aen", S_AEN, 8'd0);
    ex("t6_blink", S_BLINK, 8'd0);
    ex("t6_hold", S_HOLD, 8'd0);
    cyc(B_NONE);
    rst = 1'b0;
    ex("t6_tinc_after", S_TINC, 8'd0);
    ex("t6_aen_after", S_AEN, 8'd0);
    cyc(B_NONE);
    cyc(B_NONE);

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
